compat_multiply: RTL and testbench
==================================

COMPAT_MULTIPLY -- requirements
Module: compat_multiply

Interface
REQ-001 SHALL have parameter WIDTHA, default 8: multiplicand width, >=2.
REQ-002 SHALL have parameter WIDTHB, default 8: multiplier width, >=2; also the iteration count.
REQ-003 SHALL have parameter REP, default "UNSIGNED": operand representation, "UNSIGNED" or "SIGNED"; any other value SHALL fail elaboration.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port aclr  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clken  input  1  global clock enable; low freezes all state.
REQ-007 SHALL have port in_valid  input  1  operand pair offered.
REQ-008 SHALL have port in_ready  output  1  block can accept operands.
REQ-009 SHALL have port a  input  WIDTHA  multiplicand.
REQ-010 SHALL have port b  input  WIDTHB  multiplier.
REQ-011 SHALL have port out_valid  output  1  product available.
REQ-012 SHALL have port out_ready  input  1  consumer takes product.
REQ-013 SHALL have port product  output  WIDTHA+WIDTHB  registered result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all transitions only on rising clock edges with clken=1.
REQ-015 in_ready SHALL equal (state==IDLE) && clken; no acceptance in RUN or DONE.
REQ-016 Accept (in_valid && in_ready at edge) SHALL: load mcand = |a| zero-extended to WIDTHA+WIDTHB, mplier = |b| as WIDTHB-bit unsigned, acc = 0, count = 0, neg = sign(a) XOR sign(b) (neg = 0 when REP="UNSIGNED"); go to RUN.
REQ-017 Magnitudes SHALL be WIDTH-bit unsigned so the most negative signed value (e.g. -128 -> 0x80) is exact.
REQ-018 Each RUN edge SHALL: acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1; count += 1.
REQ-019 On the RUN edge where count reaches WIDTHB, SHALL go to DONE and register product = neg ? -(acc_next) : acc_next, modulo 2^(WIDTHA+WIDTHB).
REQ-020 Latency SHALL be exactly WIDTHB enabled cycles from accept edge to first cycle of out_valid=1; clken-low cycles extend it one-for-one.
REQ-021 out_valid SHALL equal (state==DONE); product SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 out_valid && out_ready at an enabled edge SHALL go to IDLE; product SHALL retain its value until the next DONE entry.
REQ-023 Zero operand SHALL produce product 0 with normal latency (no sign artefact: -0 = 0).
REQ-024 in_valid while not in IDLE SHALL be ignored; a, b SHALL need to be stable only at the accept edge.

Reset
REQ-025 aclr=1 SHALL asynchronously force state IDLE, out_valid 0, product 0, acc/mcand/mplier/count/neg 0, independent of clken.
REQ-026 aclr asserted mid-RUN or in DONE SHALL discard the operation; in_ready SHALL be 1 in the first cycle with aclr=0 and clken=1.

Configuration
REQ-027 Macro COMPAT_MULTIPLY_EARLY_OUT_EN, when defined, SHALL make a RUN edge also go to DONE when mplier>>1 == 0 after that edge, giving latency max(1, index of highest set bit of |b| + 1); |b|=0 gives latency 1.
REQ-028 Without COMPAT_MULTIPLY_EARLY_OUT_EN, latency SHALL be fixed at WIDTHB per REQ-020; product values SHALL be identical in both builds.

Verification (WIDTHA=WIDTHB=8)
REQ-029 UNSIGNED a=200, b=150 -> product 16'h7530 (30000), out_valid first high 8 cycles after accept edge.
REQ-030 SIGNED a=-128, b=-128 -> product 16'h4000; a=-7, b=5 -> product 16'hFFDD (-35); a=0, b=-1 -> 16'h0000.
REQ-031 Backpressure: out_ready=0 for 5 cycles after out_valid -> product, out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 aclr pulse 3 cycles after accept -> out_valid=0, product=0 immediately; new accept next enabled cycle completes correctly.
REQ-033 clken=0 for 4 cycles mid-RUN -> out_valid after 12 cycles, product still correct; in_ready=0 while clken=0.
REQ-034 EARLY_OUT build: UNSIGNED b=1, a=9 -> product 9 after 1 cycle; b=0x80 -> 8 cycles; non-EARLY_OUT build -> 8 cycles for both.

Source files
------------

// File: rtl/compat_multiply.sv
// compat_multiply -- sequential shift-add multiplier with a valid/ready handshake.
//
// Takes one operand pair in IDLE, then spends one enabled cycle per multiplier bit
// adding the shifted multiplicand into the accumulator. After that it holds the
// product in DONE until the consumer takes it. Signed operands are multiplied as
// magnitudes, and the sign is applied when the result is registered.
//
// Optional feature: define COMPAT_MULTIPLY_EARLY_OUT_EN to leave RUN as soon as
// no set multiplier bits remain. This shortens latency; product values are unchanged.
//
// Parameters: WIDTHA (multiplicand width), WIDTHB (multiplier width / iteration
//             count), REP ("UNSIGNED" or "SIGNED").
// Ports:
//   clock      rising-edge clock
//   aclr       asynchronous active-high reset
//   clken      clock enable; low freezes every register
//   in_valid   operand pair offered      in_ready   accepting (IDLE && clken)
//   a, b       multiplicand, multiplier
//   out_valid  product held (DONE)        out_ready  consumer takes product
//   product    registered WIDTHA+WIDTHB result
module compat_multiply #(
  parameter int    WIDTHA = 8,
  parameter int    WIDTHB = 8,
  parameter string REP    = "UNSIGNED"
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     clken,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTHA-1:0]        a,
  input  logic [WIDTHB-1:0]        b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTHA+WIDTHB-1:0] product
);

  localparam int PW = WIDTHA + WIDTHB;
  localparam int CW = $clog2(WIDTHB + 1);
  localparam logic IS_SIGNED = (REP == "SIGNED");

  if (REP != "SIGNED" && REP != "UNSIGNED") begin : g_bad_rep
    $error("compat_multiply: REP must be \"UNSIGNED\" or \"SIGNED\"");
  end
  if (WIDTHA < 2 || WIDTHB < 2) begin : g_bad_width
    $error("compat_multiply: WIDTHA and WIDTHB must be >= 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTHB-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;

  // Magnitudes are kept at full operand width, so the most negative value
  // maps to its exact unsigned magnitude (e.g. 8'h80 -> 128).
  logic            a_neg, b_neg;
  logic [WIDTHA-1:0] a_mag;
  logic [WIDTHB-1:0] b_mag;

  always_comb begin
    a_neg = IS_SIGNED & a[WIDTHA-1];
    b_neg = IS_SIGNED & b[WIDTHB-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    in_ready  = (state_q == IDLE) && clken;
    out_valid = (state_q == DONE);

    if (clken) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_d  = {{WIDTHB{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            count_d  = '0;
            neg_d    = a_neg ^ b_neg;
            state_d  = RUN;
          end
        end
        RUN: begin
          acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
`ifdef COMPAT_MULTIPLY_EARLY_OUT_EN
          // No remaining multiplier bits: the rest of the iterations add nothing.
          if (count_d == CW'(WIDTHB) || mplier_d == '0) begin
`else
          if (count_d == CW'(WIDTHB)) begin
`endif
            state_d   = DONE;
            product_d = neg_q ? (~acc_d + 1'b1) : acc_d;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_compat_multiply.sv
module tb_compat_multiply;

  logic        clock = 1'b0;
  logic        aclr  = 1'b1;
  logic        clken = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] product   [2];

  int checks = 0;
  int errors = 0;

  compat_multiply #(.WIDTHA(8), .WIDTHB(8), .REP("UNSIGNED")) u_dut_u (
    .clock(clock), .aclr(aclr), .clken(clken),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a), .b(b),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0]));

  compat_multiply #(.WIDTHA(8), .WIDTHB(8), .REP("SIGNED")) u_dut_s (
    .clock(clock), .aclr(aclr), .clken(clken),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a), .b(b),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1]));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_prod(input int sel, input logic [7:0] av, input logic [7:0] bv);
    int x, y;
    x = sel ? int'($signed(av)) : int'(av);
    y = sel ? int'($signed(bv)) : int'(bv);
    return 16'(x * y);
  endfunction

  function automatic int ref_lat(input int sel, input logic [7:0] bv);
    int m, lat;
    m = sel ? int'($signed(bv)) : int'(bv);
    if (m < 0) m = -m;
    lat = 8;
`ifdef COMPAT_MULTIPLY_EARLY_OUT_EN
    lat = 1;
    for (int i = 0; i < 9; i++) if ((m >> i) != 0) lat = i + 1;
`endif
    return lat;
  endfunction

  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_p, input string nm);
    int lat, exp_lat;
    exp_lat = ref_lat(sel, bv);
    @(negedge clock);
    a = av; b = bv; in_valid[sel] = 1'b1;
    checks++; if (in_ready[sel] !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %0h", nm, in_ready[sel]); end
    @(negedge clock);
    in_valid[sel] = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!out_valid[sel] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat); end
    checks++; if (product[sel] !== exp_p) begin errors++; $display("FAIL %s product: got %0h expected %0h", nm, product[sel], exp_p); end
    out_ready[sel] = 1'b1;
    @(negedge clock);
    out_ready[sel] = 1'b0;
    checks++; if (out_valid[sel] !== 1'b0) begin errors++; $display("FAIL %s out_valid after take", nm); end
    checks++; if (in_ready[sel] !== 1'b1) begin errors++; $display("FAIL %s in_ready after take", nm); end
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int lat;
    logic [7:0] ra, rb;

    vecs[0] = '{0, 8'd200, 8'd150, 16'h7530};
    vecs[1] = '{1, 8'h80,  8'h80,  16'h4000};
    vecs[2] = '{1, 8'hF9,  8'h05,  16'hFFDD};
    vecs[3] = '{1, 8'h00,  8'hFF,  16'h0000};
    vecs[4] = '{0, 8'h00,  8'h00,  16'h0000};
    vecs[5] = '{0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[6] = '{1, 8'h7F,  8'h80,  16'hC080};
    vecs[7] = '{0, 8'd9,   8'd1,   16'h0009};
    vecs[8] = '{0, 8'd3,   8'h80,  16'h0180};
    vecs[9] = '{1, 8'hFF,  8'hFF,  16'h0001};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
    end

    #3;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL reset out_valid u"); end
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL reset out_valid s"); end
    checks++; if (product[0] !== 16'h0000) begin errors++; $display("FAIL reset product u: %0h", product[0]); end
    checks++; if (product[1] !== 16'h0000) begin errors++; $display("FAIL reset product s: %0h", product[1]); end
    @(negedge clock);
    @(negedge clock);
    aclr = 1'b0;
    @(negedge clock);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL post-reset in_ready u"); end
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL post-reset in_ready s"); end

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if (i % 10 == 0) rb = 8'($urandom_range(0, 3));
      run_op(i % 2, ra, rb, ref_prod(i % 2, ra, rb), $sformatf("rand%0d", i));
    end

    @(negedge clock);
    a = 8'd200; b = 8'd150; in_valid[0] = 1'b1;
    @(negedge clock);
    a = 8'd1; b = 8'd1;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp latency: %0d", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp out_valid"); end
      checks++; if (product[0] !== 16'h7530) begin errors++; $display("FAIL bp product: %0h", product[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp in_ready"); end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clock);
    out_ready[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp release out_valid"); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp release in_ready"); end
    checks++; if (product[0] !== 16'h7530) begin errors++; $display("FAIL bp product retained: %0h", product[0]); end

    a = 8'd7; b = 8'd11; in_valid[0] = 1'b1;
    @(negedge clock);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clock);
    aclr = 1'b1;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL aclr out_valid"); end
    checks++; if (product[0] !== 16'h0000) begin errors++; $display("FAIL aclr product: %0h", product[0]); end
    @(negedge clock);
    aclr = 1'b0;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL aclr release in_ready"); end
    run_op(0, 8'd13, 8'd17, 16'd221, "after aclr");

    @(negedge clock);
    a = 8'd200; b = 8'd150; in_valid[0] = 1'b1;
    @(negedge clock);
    in_valid[0] = 1'b0;
    lat = 0;
    repeat (2) begin @(negedge clock); lat++; end
    clken = 1'b0;
    repeat (4) begin
      #1;
      checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL clken-low in_ready idle inst"); end
      @(negedge clock); lat++;
    end
    clken = 1'b1;
    while (!out_valid[0] && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    checks++; if (lat !== 12) begin errors++; $display("FAIL clken latency: %0d", lat); end
    checks++; if (product[0] !== 16'h7530) begin errors++; $display("FAIL clken product: %0h", product[0]); end
    out_ready[0] = 1'b1;
    @(negedge clock);
    out_ready[0] = 1'b0;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL clken final in_ready"); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
